// File: rtl/cs_microseq.sv
// Microcode sequencer: forms the micro-address, captures the ROM control word,
// advances the micro-step, and handles stall, CB paging, HALT and step overflow.
module cs_microseq #(
   parameter int unsigned CW_WIDTH   = 76,
   parameter int unsigned STEP_WIDTH = 3,
   parameter int unsigned ADV_LSB    = 36,
   parameter int unsigned TOGGLE_BIT = 53,
   parameter int unsigned HALT_BIT   = 39,
   parameter logic [CW_WIDTH-1:0] STROBE_MASK = '0
) (
   input  logic                      clock,
   input  logic                      nreset,
   input  logic [CW_WIDTH-1:0]       rom_word,
   input  logic [7:0]                opcode,
   input  logic                      stall,
   input  logic                      cond,
   input  logic                      irq_pending,
   output logic [9+STEP_WIDTH-1:0]   uaddr,
   output logic [CW_WIDTH-1:0]       cs_word,
   output logic                      instr_done,
   output logic                      halted,
   output logic                      uerr
);

   localparam int unsigned SW1 = STEP_WIDTH + 1;

   typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                state, state_next;
   logic [STEP_WIDTH-1:0] step, step_next;
   logic                  cb_mode, cb_next;
   logic [CW_WIDTH-1:0]   cw_reg, cw_next;
   logic                  done_next, uerr_next, halted_next;
   logic [1:0]            adv, inc;
   logic [SW1-1:0]        step_sum;

   assign adv = rom_word[ADV_LSB+1:ADV_LSB];

   // State and datapath registers
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state      <= RUN;
         step       <= '0;
         cb_mode    <= 1'b0;
         cw_reg     <= '0;
         instr_done <= 1'b0;
         uerr       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_next;
         step       <= step_next;
         cb_mode    <= cb_next;
         cw_reg     <= cw_next;
         instr_done <= done_next;
         uerr       <= uerr_next;
         halted     <= halted_next;
      end
   end

   // Next-state and sequencing logic
   always_comb begin
      state_next  = state;
      step_next   = step;
      cb_next     = cb_mode;
      cw_next     = cw_reg;
      done_next   = 1'b0;
      uerr_next   = uerr;
      halted_next = 1'b0;
      inc         = 2'd0;
      step_sum    = '0;
      case (state)
         RUN: begin
            if (!stall) begin
               cw_next = rom_word;
               case (adv)
                  2'd0: inc = 2'd1;
                  2'd1: begin
                     step_next = '0;
                     cb_next   = cb_mode ^ rom_word[TOGGLE_BIT];
                     done_next = 1'b1;
                     if (rom_word[HALT_BIT]) state_next = HALT;
                  end
                  2'd2: inc = 2'd0;
                  2'd3: inc = cond ? 2'd2 : 2'd1;
               endcase
               if (adv == 2'd0 || adv == 2'd3) begin
                  step_sum  = {1'b0, step} + SW1'(inc);
                  step_next = step_sum[STEP_WIDTH-1:0];
                  if (step_sum[STEP_WIDTH]) uerr_next = 1'b1;
               end
            end
         end
         HALT: begin
            // halted gates the wake so HALT is visible for at least one cycle
            cw_next   = '0;
            step_next = '0;
            if (irq_pending && halted) state_next = RUN;
            else                       halted_next = 1'b1;
         end
         default: state_next = RUN;
      endcase
   end

   assign uaddr   = {cb_mode, opcode, step};
   assign cs_word = stall ? (cw_reg & ~STROBE_MASK) : cw_reg;

endmodule

// File: tb/tb_cs_microseq.sv
// Directed self-checking bench for cs_microseq.
module tb_cs_microseq;

   localparam logic [75:0] SMASK = 76'd1 << 48;

   logic        clock = 1'b0;
   logic        nreset;
   logic [75:0] rom_word;
   logic [7:0]  opcode;
   logic        stall, cond, irq_pending;
   logic [11:0] uaddr;
   logic [75:0] cs_word;
   logic        instr_done, halted, uerr;

   int checks   = 0;
   int failures = 0;

   cs_microseq #(.STROBE_MASK(SMASK)) dut (
      .clock(clock), .nreset(nreset), .rom_word(rom_word), .opcode(opcode),
      .stall(stall), .cond(cond), .irq_pending(irq_pending), .uaddr(uaddr),
      .cs_word(cs_word), .instr_done(instr_done), .halted(halted), .uerr(uerr)
   );

   always #5 clock = ~clock;

   function automatic logic [75:0] mk(input logic [1:0] adv, input logic tog,
                                      input logic hlt, input logic s48,
                                      input logic [15:0] tag);
      logic [75:0] w;
      w        = '0;
      w[37:36] = adv;
      w[53]    = tog;
      w[39]    = hlt;
      w[48]    = s48;
      w[15:0]  = tag;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   logic [75:0] w;

   initial begin
      nreset = 1'b1; rom_word = '0; opcode = 8'h3E;
      stall = 1'b0; cond = 1'b0; irq_pending = 1'b0;
      #1 nreset = 1'b0;
      #1;
      chk("rst_uaddr", uaddr, 12'h1F0);
      chk("rst_cs", cs_word, 76'h0);
      chk("rst_done", instr_done, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_uerr", uerr, 1'b0);
      #10 nreset = 1'b1;

      // 3-step instruction 0,0,1
      rom_word = mk(2'd0, 0, 0, 0, 16'h1001);
      chk("i0_uaddr0", uaddr, 12'h1F0);
      tick;
      chk("i0_cs0", cs_word, mk(2'd0, 0, 0, 0, 16'h1001));
      chk("i0_uaddr1", uaddr, 12'h1F1);
      chk("i0_done0", instr_done, 1'b0);
      rom_word = mk(2'd0, 0, 0, 0, 16'h1002);
      tick;
      chk("i0_cs1", cs_word, mk(2'd0, 0, 0, 0, 16'h1002));
      chk("i0_uaddr2", uaddr, 12'h1F2);
      rom_word = mk(2'd1, 0, 0, 0, 16'h1003);
      tick;
      chk("i0_cs2", cs_word, mk(2'd1, 0, 0, 0, 16'h1003));
      chk("i0_uaddr_end", uaddr, 12'h1F0);
      chk("i0_done1", instr_done, 1'b1);
      rom_word = mk(2'd2, 0, 0, 0, 16'h1004);
      tick;
      chk("rep_done", instr_done, 1'b0);
      chk("rep_uaddr", uaddr, 12'h1F0);

      // Stall with strobe bit 48
      rom_word = mk(2'd0, 0, 0, 1, 16'h2000);
      tick;
      chk("st_cap", cs_word, mk(2'd0, 0, 0, 1, 16'h2000));
      stall = 1'b1;
      rom_word = mk(2'd0, 0, 0, 0, 16'h2001);
      #0;
      chk("st_mask0", cs_word[48], 1'b0);
      tick;
      chk("st_mask1", cs_word[48], 1'b0);
      chk("st_hold1", uaddr, 12'h1F1);
      tick;
      chk("st_mask2", cs_word[48], 1'b0);
      tick;
      chk("st_hold3", uaddr, 12'h1F1);
      stall = 1'b0;
      #0;
      chk("st_fire", cs_word, mk(2'd0, 0, 0, 1, 16'h2000));
      tick;
      chk("st_next", cs_word, mk(2'd0, 0, 0, 0, 16'h2001));
      chk("st_uaddr", uaddr, 12'h1F2);

      // CB prefix paging
      rom_word = mk(2'd1, 1, 0, 0, 16'h3000);
      tick;
      chk("cb_on", uaddr, 12'h9F0);
      opcode = 8'h7C;
      #0;
      chk("cb_op", uaddr, 12'hBE0);
      rom_word = mk(2'd0, 0, 0, 0, 16'h3001);
      tick;
      chk("cb_s1", uaddr, 12'hBE1);
      rom_word = mk(2'd3, 0, 0, 0, 16'h3002);
      cond = 1'b1;
      tick;
      chk("skip_c1", uaddr, 12'hBE3);
      rom_word = mk(2'd1, 1, 0, 0, 16'h3003);
      tick;
      chk("cb_off", uaddr, 12'h3E0);

      // Skip with cond=0, then overflow
      rom_word = mk(2'd0, 0, 0, 0, 16'h3100);
      tick;
      rom_word = mk(2'd3, 0, 0, 0, 16'h3101);
      cond = 1'b0;
      tick;
      chk("skip_c0", uaddr, 12'h3E2);
      chk("uerr_clear", uerr, 1'b0);
      rom_word = mk(2'd0, 0, 0, 0, 16'h3200);
      for (int i = 0; i < 5; i++) tick;
      chk("step7", uaddr, 12'h3E7);
      chk("uerr_pre", uerr, 1'b0);
      tick;
      chk("wrap_step", uaddr, 12'h3E0);
      chk("wrap_uerr", uerr, 1'b1);
      rom_word = mk(2'd2, 0, 0, 0, 16'h3300);
      tick;
      tick;
      chk("uerr_sticky", uerr, 1'b1);

      // HALT and wake
      w = mk(2'd1, 0, 1, 0, 16'h4000);
      rom_word = w;
      tick;
      chk("h_cap", cs_word, w);
      chk("h_done", instr_done, 1'b1);
      chk("h_notyet", halted, 1'b0);
      rom_word = mk(2'd0, 0, 0, 0, 16'h4001);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("h_halted", halted, 1'b1);
         chk("h_cs0", cs_word, 76'h0);
         chk("h_uaddr", uaddr, 12'h3E0);
      end
      irq_pending = 1'b1;
      tick;
      irq_pending = 1'b0;
      chk("w_halted", halted, 1'b0);
      chk("w_uaddr", uaddr, 12'h3E0);
      rom_word = mk(2'd0, 0, 0, 0, 16'h5000);
      tick;
      chk("w_cs", cs_word, mk(2'd0, 0, 0, 0, 16'h5000));
      chk("w_uaddr1", uaddr, 12'h3E1);

      // Reset while halted
      rom_word = mk(2'd1, 0, 1, 0, 16'h6000);
      tick;
      rom_word = '0;
      tick;
      chk("r_halted_pre", halted, 1'b1);
      #2 nreset = 1'b0;
      #1;
      chk("r_halted", halted, 1'b0);
      chk("r_uerr", uerr, 1'b0);
      chk("r_cs", cs_word, 76'h0);
      chk("r_uaddr", uaddr, 12'h3E0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cs_microseq.md
# cs_microseq

Parametrised microcode sequencer and control-word register for the CPU control unit. It forms the micro-address from the CB-page flag, the current opcode and the micro-step counter, and captures the control word returned by the microcode ROM. It advances the micro-step according to the word's advance field and drives the control word to the field mapper. It also adds what the flat field mapper lacks: bus-stall freezing with one-shot strobe suppression, CB-prefix paging, a HALT state with interrupt wake-up, and micro-step overflow detection.

## Interface
- CW_WIDTH, 76: control word width.
- STEP_WIDTH, 3: micro-step counter width.
- ADV_LSB, 36: LSB of the 2-bit advance field in the control word.
- TOGGLE_BIT, 53: CB-toggle bit position.
- HALT_BIT, 39: set-halt bit position.
- STROBE_MASK, CW_WIDTH'h0: bits set mark one-shot strobe fields (write enables, ack, ime set/clear).

Ports:
- clock  in  1  system clock; all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- rom_word  in  CW_WIDTH  microcode ROM data for the current uaddr (combinational ROM).
- opcode  in  8  current instruction-buffer byte.
- stall  in  1  bus wait; freeze sequencing.
- cond  in  1  branch condition for the conditional-skip advance.
- irq_pending  in  1  interrupt pending; wakes from HALT.
- uaddr  out  9+STEP_WIDTH  {cb_mode, opcode, step}.
- cs_word  out  CW_WIDTH  control word to the field mapper.
- instr_done  out  1  one-cycle pulse when an end-of-instruction word is captured.
- halted  out  1  high in HALT state.
- uerr  out  1  sticky micro-step overflow flag.

## Operation
- Registers: step, cb_mode, cw_reg, state {RUN, HALT}, uerr, instr_done.
- Reset values: step 0, cb_mode 0, cw_reg 0, state RUN, instr_done 0, uerr 0. All outputs are therefore 0, except that uaddr's opcode bits follow the opcode input.
- The field adv is rom_word[ADV_LSB+1:ADV_LSB].
- RUN with stall=0, each edge:
  - cw_reg <= rom_word.
  - Step update by adv:
    - 0 (next): step <= step+1.
    - 1 (end): step <= 0; cb_mode <= cb_mode ^ rom_word[TOGGLE_BIT]; instr_done <= 1.
    - 2 (repeat): step unchanged.
    - 3 (skip): step <= step + (cond ? 2 : 1).
  - Step arithmetic is modulo 2^STEP_WIDTH. Any wrap past the maximum value sets uerr, which stays set until reset.
  - instr_done is 0 on every edge where adv != 1 or the sequencer is not advancing.
- RUN with stall=1: step, cb_mode, cw_reg and state hold, and instr_done <= 0.
  - cs_word = cw_reg & ~STROBE_MASK (combinational from stall), so strobes do not fire during a stall.
  - On the cycle stall falls, cs_word = cw_reg, so the strobes fire exactly once.
- RUN to HALT: on a non-stalled edge with adv==1 and rom_word[HALT_BIT]=1, the word is captured normally and then state <= HALT.
- HALT:
  - cw_reg <= 0 each edge, step held at 0, cb_mode held, stall ignored, halted=1.
  - irq_pending=1 at an edge gives state <= RUN. Sequencing resumes from step 0 on the following edge.
- irq_pending already high when HALT is entered: HALT lasts a minimum of one cycle.
- Reset mid-stall or in HALT returns everything to the reset values immediately (asynchronous).

## Timing
- uaddr is combinational from step, cb_mode and opcode.
- The ROM word for step k appears on cs_word one cycle after step becomes k. The sequencer latency is 1 cycle.
- Stall costs exactly one extra cycle per stalled cycle. There is no skid and no lost or duplicated micro-op.
- instr_done is high in the cycle following capture of the end word, aligned with that word on cs_word.
- halted asserts in the cycle the halt word appears on cs_word + 1.

## Test plan
- Reset, then a 3-step instruction with adv sequence 0,0,1 and opcode 0x3E: step goes 0→1→2→0, uaddr = {0,0x3E,step}, instr_done pulses once, cs_word matches each ROM word one cycle later.
- STROBE_MASK bit 48 set, word with bit 48=1, stall held 3 cycles: cs_word[48]=0 for those 3 cycles, then 1 for exactly one cycle; step advances only once.
- CB prefix: end word with TOGGLE_BIT=1 gives cb_mode=1, and uaddr MSB=1 for the next instruction. After that instruction's end word with TOGGLE_BIT=1, cb_mode=0.
- Skip advance at step 1: cond=1 gives step 3; cond=0 gives step 2. With STEP_WIDTH=3, adv=0 at step 7 gives step 0 and uerr=1, which stays 1 until nreset.
- Halt word captured, then irq_pending after 5 cycles:
  - halted=1 and cs_word=0 throughout the halt.
  - halted=0 after the irq edge, and sequencing resumes at step 0.
  - Assert nreset low while halted in a separate run: halted=0 immediately.
